flu_debug_checker: RTL

Receive-side counterpart of the FLU debug generator. Sinks a FrameLinkUnaligned stream, drives a programmable RX_DST_RDY backpressure pattern, checks SOP/EOP framing and frame length, and accumulates frame, byte and error statistics. All statistics and configuration are accessible over MI32. It sits at the end of a FLU pipeline in hardware debug and loopback builds.

---
 rtl/flu_debug_checker_pkg.sv | 28 ++
 rtl/flu_frame_len.sv | 112 +++++++++++
 rtl/flu_debug_checker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/flu_debug_checker_pkg.sv
// Shared definitions for the FLU debug checker: MI32 register byte offsets,
// reset values of the programmable registers and the frame FSM state type.
package flu_debug_checker_pkg;

    // MI32 register byte offsets
    localparam logic [31:0] REG_CTRL      = 32'h00;
    localparam logic [31:0] REG_PATTERN   = 32'h04;
    localparam logic [31:0] REG_MIN_LEN   = 32'h08;
    localparam logic [31:0] REG_MAX_LEN   = 32'h0C;
    localparam logic [31:0] REG_FRAMES_LO = 32'h10;
    localparam logic [31:0] REG_FRAMES_HI = 32'h14;
    localparam logic [31:0] REG_BYTES_LO  = 32'h18;
    localparam logic [31:0] REG_BYTES_HI  = 32'h1C;
    localparam logic [31:0] REG_ERR_FRAME = 32'h20;
    localparam logic [31:0] REG_ERR_LEN   = 32'h24;
    localparam logic [31:0] REG_LAST_LEN  = 32'h28;

    // Reset values of the programmable registers
    localparam logic [31:0] PATTERN_RST = 32'hFFFF_FFFF;
    localparam logic [15:0] MIN_LEN_RST = 16'd60;
    localparam logic [15:0] MAX_LEN_RST = 16'd1526;

    typedef enum logic [0:0] {
        StIdle,
        StFrame
    } frame_state_e;

endpackage

// File: rtl/flu_frame_len.sv
// Frame framing checker and length accumulator for a FLU stream.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   xfer             : a word is transferred this cycle
//   sop, eop         : start / end of frame flags of the word
//   sop_pos, eop_pos : SOP block index, last valid byte index
//   frame_done       : one-cycle strobe, a frame completed (registered)
//   frame_len        : length of the completed frame in bytes (valid with frame_done)
//   err_framing      : one-cycle strobe, framing violation seen (registered)
module flu_frame_len
    import flu_debug_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned SOP_POS_WIDTH = 3,
    parameter int unsigned EOP_POS_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     xfer,
    input  logic                     sop,
    input  logic                     eop,
    input  logic [SOP_POS_WIDTH-1:0] sop_pos,
    input  logic [EOP_POS_WIDTH-1:0] eop_pos,
    output logic                     frame_done,
    output logic [15:0]              frame_len,
    output logic                     err_framing
);

    localparam int unsigned BW   = DATA_WIDTH / 8;
    localparam int unsigned GRAN = BW >> SOP_POS_WIDTH;

    frame_state_e state_q, state_d;
    logic [15:0]  acc_q, acc_d;
    logic         done_d, err_d;
    logic [15:0]  len_d;

    logic [15:0] sop_off, eop_ext, open_acc, cont_acc, end_len;
    logic [16:0] cont_sum, end_sum;
    logic        eop_before_sop;

    assign sop_off        = 16'(sop_pos) * 16'(GRAN);
    assign eop_ext        = 16'(eop_pos);
    assign open_acc       = 16'(BW) - sop_off;
    assign eop_before_sop = eop_ext < sop_off;

    // 17-bit sums so the 16-bit accumulator and lengths can saturate at 0xFFFF
    assign cont_sum = {1'b0, acc_q} + 17'(BW);
    assign end_sum  = {1'b0, acc_q} + {1'b0, eop_ext} + 17'd1;
    assign cont_acc = cont_sum[16] ? 16'hFFFF : cont_sum[15:0];
    assign end_len  = end_sum[16] ? 16'hFFFF : end_sum[15:0];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        done_d  = 1'b0;
        len_d   = '0;
        err_d   = 1'b0;
        if (xfer) begin
            unique case (state_q)
                StIdle: begin
                    if (!sop) begin
                        err_d = eop;
                    end else if (eop && !eop_before_sop) begin
                        done_d = 1'b1;
                        len_d  = eop_ext - sop_off + 16'd1;
                    end else begin
                        // EOP before SOP with no open frame is an orphan EOP
                        err_d   = eop;
                        acc_d   = open_acc;
                        state_d = StFrame;
                    end
                end
                StFrame: begin
                    if (!sop && !eop) begin
                        acc_d = cont_acc;
                    end else if (!sop) begin
                        done_d  = 1'b1;
                        len_d   = end_len;
                        state_d = StIdle;
                    end else if (eop && eop_before_sop) begin
                        // Back-to-back: current frame ends, next one opens in the same word
                        done_d = 1'b1;
                        len_d  = end_len;
                        acc_d  = open_acc;
                    end else begin
                        // SOP inside an open frame: drop it and restart at the new SOP
                        err_d = 1'b1;
                        acc_d = open_acc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            frame_done  <= 1'b0;
            frame_len   <= '0;
            err_framing <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            frame_done  <= done_d;
            frame_len   <= len_d;
            err_framing <= err_d;
        end
    end

endmodule

// File: rtl/flu_debug_checker.sv
// FLU debug checker: sinks a FrameLinkUnaligned stream with a programmable
// ready pattern, checks framing and frame length, keeps statistics on MI32.
// Ports:
//   CLK, RESET                      : clock, synchronous active-high reset
//   RX_DATA .. RX_SRC_RDY, RX_DST_RDY : FLU sink interface
//   MI_DWR, MI_ADDR, MI_BE, MI_RD, MI_WR : MI32 request
//   MI_DRD, MI_ARDY, MI_DRDY        : MI32 response
module flu_debug_checker
    import flu_debug_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned SOP_POS_WIDTH = 3,
    parameter int unsigned EOP_POS_WIDTH = 6
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_WIDTH-1:0]    RX_DATA,
    input  logic [SOP_POS_WIDTH-1:0] RX_SOP_POS,
    input  logic [EOP_POS_WIDTH-1:0] RX_EOP_POS,
    input  logic                     RX_SOP,
    input  logic                     RX_EOP,
    input  logic                     RX_SRC_RDY,
    output logic                     RX_DST_RDY,
    input  logic [31:0]              MI_DWR,
    input  logic [31:0]              MI_ADDR,
    input  logic [3:0]               MI_BE,
    input  logic                     MI_RD,
    input  logic                     MI_WR,
    output logic [31:0]              MI_DRD,
    output logic                     MI_ARDY,
    output logic                     MI_DRDY
);

    logic        ctrl_en_q;
    logic [31:0] pattern_q;
    logic [15:0] min_len_q, max_len_q;
    logic [4:0]  idx_q;
    logic [63:0] frames_q, bytes_q;
    logic [31:0] err_framing_q, err_length_q;
    logic [15:0] last_len_q;
    logic [31:0] frames_hi_snap_q, bytes_hi_snap_q;
    logic [31:0] drd_q;
    logic        drdy_q;
    logic [31:0] rd_data;

    logic        xfer, frame_done, err_framing, len_err, clr;
    logic        wr_ctrl, wr_pattern, wr_min_len, wr_max_len;
    logic [15:0] frame_len;

    // Payload and byte enables are deliberately not inspected
    logic unused_inputs;
    assign unused_inputs = ^{RX_DATA, MI_BE};

    assign RX_DST_RDY = ctrl_en_q & pattern_q[idx_q];
    assign xfer       = RX_SRC_RDY & RX_DST_RDY;

    assign MI_ARDY = MI_RD | MI_WR;
    assign MI_DRD  = drd_q;
    assign MI_DRDY = drdy_q;

    assign wr_ctrl    = MI_WR && (MI_ADDR == REG_CTRL);
    assign wr_pattern = MI_WR && (MI_ADDR == REG_PATTERN);
    assign wr_min_len = MI_WR && (MI_ADDR == REG_MIN_LEN);
    assign wr_max_len = MI_WR && (MI_ADDR == REG_MAX_LEN);
    assign clr        = wr_ctrl & MI_DWR[1];

    assign len_err = (frame_len < min_len_q) || (frame_len > max_len_q);

    flu_frame_len #(
        .DATA_WIDTH    (DATA_WIDTH),
        .SOP_POS_WIDTH (SOP_POS_WIDTH),
        .EOP_POS_WIDTH (EOP_POS_WIDTH)
    ) u_frame_len (
        .clk         (CLK),
        .reset       (RESET),
        .xfer        (xfer),
        .sop         (RX_SOP),
        .eop         (RX_EOP),
        .sop_pos     (RX_SOP_POS),
        .eop_pos     (RX_EOP_POS),
        .frame_done  (frame_done),
        .frame_len   (frame_len),
        .err_framing (err_framing)
    );

    // Configuration and backpressure pattern index
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ctrl_en_q <= 1'b0;
            pattern_q <= PATTERN_RST;
            min_len_q <= MIN_LEN_RST;
            max_len_q <= MAX_LEN_RST;
            idx_q     <= '0;
        end else begin
            idx_q <= idx_q + 5'd1;
            if (wr_ctrl)    ctrl_en_q <= MI_DWR[0];
            if (wr_pattern) pattern_q <= MI_DWR;
            if (wr_min_len) min_len_q <= MI_DWR[15:0];
            if (wr_max_len) max_len_q <= MI_DWR[15:0];
        end
    end

    // Statistics; a CLR pulse overrides any increment in the same cycle
    always_ff @(posedge CLK) begin
        if (RESET || clr) begin
            frames_q      <= '0;
            bytes_q       <= '0;
            err_framing_q <= '0;
            err_length_q  <= '0;
            last_len_q    <= '0;
        end else begin
            if (frame_done) begin
                frames_q   <= frames_q + 64'd1;
                bytes_q    <= bytes_q + 64'(frame_len);
                last_len_q <= frame_len;
                if (len_err && (err_length_q != 32'hFFFF_FFFF)) begin
                    err_length_q <= err_length_q + 32'd1;
                end
            end
            if (err_framing && (err_framing_q != 32'hFFFF_FFFF)) begin
                err_framing_q <= err_framing_q + 32'd1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (MI_ADDR)
            REG_CTRL:      rd_data = {31'b0, ctrl_en_q};
            REG_PATTERN:   rd_data = pattern_q;
            REG_MIN_LEN:   rd_data = {16'b0, min_len_q};
            REG_MAX_LEN:   rd_data = {16'b0, max_len_q};
            REG_FRAMES_LO: rd_data = frames_q[31:0];
            REG_FRAMES_HI: rd_data = frames_hi_snap_q;
            REG_BYTES_LO:  rd_data = bytes_q[31:0];
            REG_BYTES_HI:  rd_data = bytes_hi_snap_q;
            REG_ERR_FRAME: rd_data = err_framing_q;
            REG_ERR_LEN:   rd_data = err_length_q;
            REG_LAST_LEN:  rd_data = {16'b0, last_len_q};
            default:       rd_data = '0;
        endcase
    end

    // Reading a lo word latches the hi word so a lo/hi pair is coherent
    always_ff @(posedge CLK) begin
        if (RESET) begin
            drdy_q           <= 1'b0;
            drd_q            <= '0;
            frames_hi_snap_q <= '0;
            bytes_hi_snap_q  <= '0;
        end else begin
            drdy_q <= MI_RD;
            drd_q  <= MI_RD ? rd_data : 32'd0;
            if (MI_RD && (MI_ADDR == REG_FRAMES_LO)) frames_hi_snap_q <= frames_q[63:32];
            if (MI_RD && (MI_ADDR == REG_BYTES_LO))  bytes_hi_snap_q  <= bytes_q[63:32];
        end
    end

endmodule
